fetch_queue: RTL and testbench

Parametrised instruction queue between the fetch stage and decode. Generalises the single-entry fetch pipeline register into a DEPTH-entry first-in-first-out buffer with a valid/ready handshake on both sides, back-pressure, and a synchronous flush for branch redirects. Each entry holds one instruction word and its PC. Fetch pushes on the input side; decode pops on the output side.

---
 rtl/fetch_queue_if.sv | 33 +++
 rtl/fetch_queue.sv | 80 ++++++++
 tb/tb_fetch_queue.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Handshake and status bundle between fetch, the fetch queue and decode.
// The slave modport is the queue; the master modport is the fetch/decode side.
interface fetch_queue_if #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned DEPTH_BITS   = 2
);
    logic                    flush;
    logic [DATA_WIDTH-1:0]   in_instruction;
    logic [ADDRESS_BITS-1:0] in_PC;
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   out_instruction;
    logic [ADDRESS_BITS-1:0] out_PC;
    logic                    out_valid;
    logic                    out_ready;
    logic [DEPTH_BITS:0]     count;
    logic                    full;
    logic                    almost_full;
    logic                    empty;

    modport slave (
        input  flush, in_instruction, in_PC, in_valid, out_ready,
        output in_ready, out_instruction, out_PC, out_valid,
               count, full, almost_full, empty
    );

    modport master (
        output flush, in_instruction, in_PC, in_valid, out_ready,
        input  in_ready, out_instruction, out_PC, out_valid,
               count, full, almost_full, empty
    );
endinterface

// File: rtl/fetch_queue.sv
// DEPTH-entry instruction FIFO between fetch and decode with valid/ready on
// both sides and a synchronous flush for redirects. Outputs depend only on state.
module fetch_queue #(
    parameter int          CORE         = 0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDRESS_BITS = 20,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DEPTH_BITS   = 2
) (
    input logic            clock,
    input logic            reset,
    fetch_queue_if.slave   bus
);
    localparam int unsigned PW = DEPTH_BITS;
    localparam int unsigned CW = DEPTH_BITS + 1;

    if (CORE < 0 || DEPTH < 2 || DEPTH != (32'd1 << DEPTH_BITS)) begin : g_param_check
        $error("fetch_queue: DEPTH must be a power of two >= 2 matching DEPTH_BITS");
    end

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   instruction;
        logic [ADDRESS_BITS-1:0] pc;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic            full_c;
    logic            empty_c;
    logic            push_c;
    logic            pop_c;

    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == CW'(0));
    assign push_c  = bus.in_valid & ~full_c;
    assign pop_c   = ~empty_c & bus.out_ready;

    // Pointer and occupancy state; flush wins over any same-cycle push or pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
            if (push_c && !pop_c)      count_q <= count_q + CW'(1);
            else if (pop_c && !push_c) count_q <= count_q - CW'(1);
        end
    end

    // Storage is never reset; a flushed push must not land.
    always_ff @(posedge clock) begin
        if (push_c && !bus.flush) begin
            mem[wr_ptr] <= '{instruction: bus.in_instruction, pc: bus.in_PC};
        end
    end

    always_comb begin
        bus.out_instruction = '0;
        bus.out_PC          = '0;
        if (!empty_c) begin
            bus.out_instruction = mem[rd_ptr].instruction;
            bus.out_PC          = mem[rd_ptr].pc;
        end
    end

    assign bus.out_valid   = ~empty_c;
    assign bus.in_ready    = ~full_c;
    assign bus.count       = count_q;
    assign bus.full        = full_c;
    assign bus.empty       = empty_c;
    assign bus.almost_full = (count_q >= CW'(DEPTH - 1));
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_fetch_queue;
    localparam int unsigned DW    = 32;
    localparam int unsigned AB    = 20;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DB    = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_queue_if #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .DEPTH_BITS(DB)) bus ();

    fetch_queue #(
        .CORE(0), .DATA_WIDTH(DW), .ADDRESS_BITS(AB), .DEPTH(DEPTH), .DEPTH_BITS(DB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct packed {
        logic [DW-1:0] instr;
        logic [AB-1:0] pc;
    } ent_t;

    typedef struct {
        logic          flush;
        logic          in_valid;
        logic          out_ready;
        logic [DW-1:0] instr;
        logic [AB-1:0] pc;
        int            exp_count;
        logic [DW-1:0] exp_instr;
        logic [AB-1:0] exp_pc;
    } vec_t;

    ent_t mq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour: a plain queue, cleared on flush, capped at DEPTH.
    task automatic model_edge(input logic f, input logic iv, input logic ordy,
                              input logic [DW-1:0] instr, input logic [AB-1:0] pc);
        bit can_push;
        bit can_pop;
        ent_t e;
        can_push = (mq.size() < DEPTH);
        can_pop  = (mq.size() > 0) && ordy;
        if (f) begin
            mq.delete();
        end else begin
            if (can_pop) void'(mq.pop_front());
            if (iv && can_push) begin
                e.instr = instr;
                e.pc    = pc;
                mq.push_back(e);
            end
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"},     64'(bus.count),           64'(n));
        chk({tag, ".out_valid"}, 64'(bus.out_valid),       64'(n > 0));
        chk({tag, ".empty"},     64'(bus.empty),           64'(n == 0));
        chk({tag, ".full"},      64'(bus.full),            64'(n == DEPTH));
        chk({tag, ".almost"},    64'(bus.almost_full),     64'(n >= DEPTH - 1));
        chk({tag, ".in_ready"},  64'(bus.in_ready),        64'(n < DEPTH));
        chk({tag, ".instr"},     64'(bus.out_instruction), 64'((n > 0) ? mq[0].instr : '0));
        chk({tag, ".pc"},        64'(bus.out_PC),          64'((n > 0) ? mq[0].pc : '0));
    endtask

    task automatic cycle(input logic f, input logic iv, input logic ordy,
                         input logic [DW-1:0] instr, input logic [AB-1:0] pc);
        bus.flush          = f;
        bus.in_valid       = iv;
        bus.out_ready      = ordy;
        bus.in_instruction = instr;
        bus.in_PC          = pc;
        @(posedge clock);
        model_edge(f, iv, ordy, instr, pc);
        #1;
    endtask

    function automatic vec_t mk(logic f, logic iv, logic ordy, logic [DW-1:0] instr,
                                logic [AB-1:0] pc, int ec, logic [DW-1:0] ei, logic [AB-1:0] ep);
        vec_t v;
        v.flush = f; v.in_valid = iv; v.out_ready = ordy; v.instr = instr; v.pc = pc;
        v.exp_count = ec; v.exp_instr = ei; v.exp_pc = ep;
        return v;
    endfunction

    task automatic do_reset();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        reset = 1'b1;
        mq.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    vec_t vecs[11];

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in_instruction = '0; bus.in_PC = '0;

        // Expected state after each edge of the directed sequence.
        vecs[0]  = mk(0, 1, 0, 32'hA0000001, 20'h00004, 1, 32'hA0000001, 20'h00004);
        vecs[1]  = mk(0, 1, 0, 32'hA0000002, 20'h00008, 2, 32'hA0000001, 20'h00004);
        vecs[2]  = mk(0, 1, 0, 32'hA0000003, 20'h0000C, 3, 32'hA0000001, 20'h00004);
        vecs[3]  = mk(0, 1, 0, 32'hA0000004, 20'h00010, 4, 32'hA0000001, 20'h00004);
        vecs[4]  = mk(0, 1, 0, 32'hA0000005, 20'h00014, 4, 32'hA0000001, 20'h00004);
        vecs[5]  = mk(0, 1, 1, 32'hA0000006, 20'h00018, 3, 32'hA0000002, 20'h00008);
        vecs[6]  = mk(0, 1, 0, 32'hA0000006, 20'h00018, 4, 32'hA0000002, 20'h00008);
        vecs[7]  = mk(0, 0, 1, 32'h0,        20'h0,     3, 32'hA0000003, 20'h0000C);
        vecs[8]  = mk(1, 1, 0, 32'hA0000007, 20'h0001C, 0, 32'h0,        20'h0);
        vecs[9]  = mk(0, 1, 0, 32'hB0000001, 20'h00020, 1, 32'hB0000001, 20'h00020);
        vecs[10] = mk(0, 0, 1, 32'h0,        20'h0,     0, 32'h0,        20'h0);

        do_reset();
        chk("reset.count",     64'(bus.count),           64'd0);
        chk("reset.out_valid", 64'(bus.out_valid),       64'd0);
        chk("reset.empty",     64'(bus.empty),           64'd1);
        chk("reset.full",      64'(bus.full),            64'd0);
        chk("reset.almost",    64'(bus.almost_full),     64'd0);
        chk("reset.in_ready",  64'(bus.in_ready),        64'd1);
        chk("reset.instr",     64'(bus.out_instruction), 64'd0);
        chk("reset.pc",        64'(bus.out_PC),          64'd0);

        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready, vecs[i].instr, vecs[i].pc);
            chk($sformatf("vec%0d.count", i),  64'(bus.count),           64'(vecs[i].exp_count));
            chk($sformatf("vec%0d.valid", i),  64'(bus.out_valid),       64'(vecs[i].exp_count > 0));
            chk($sformatf("vec%0d.full", i),   64'(bus.full),            64'(vecs[i].exp_count == 4));
            chk($sformatf("vec%0d.almost", i), 64'(bus.almost_full),     64'(vecs[i].exp_count >= 3));
            chk($sformatf("vec%0d.ready", i),  64'(bus.in_ready),        64'(vecs[i].exp_count < 4));
            chk($sformatf("vec%0d.empty", i),  64'(bus.empty),           64'(vecs[i].exp_count == 0));
            chk($sformatf("vec%0d.instr", i),  64'(bus.out_instruction), 64'(vecs[i].exp_instr));
            chk($sformatf("vec%0d.pc", i),     64'(bus.out_PC),          64'(vecs[i].exp_pc));
        end

        // Streaming through two pointer wraps: occupancy stays at one.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, 1, 32'hC0000000 + DW'(i), AB'(i * 4));
            chk($sformatf("stream%0d.count", i), 64'(bus.count),           64'd1);
            chk($sformatf("stream%0d.instr", i), 64'(bus.out_instruction), 64'(32'hC0000000 + i));
            chk($sformatf("stream%0d.pc", i),    64'(bus.out_PC),          64'(i * 4));
        end
        cycle(0, 0, 1, '0, '0);
        check_model("stream_drain");

        // Asynchronous reset mid-cycle with two entries held.
        cycle(0, 1, 0, 32'hD0000001, 20'h00100);
        cycle(0, 1, 0, 32'hD0000002, 20'h00104);
        chk("pre_rst.count", 64'(bus.count), 64'd2);
        bus.in_valid = 1'b0;
        #2 reset = 1'b1;
        mq.delete();
        #1;
        chk("async_rst.count",     64'(bus.count),     64'd0);
        chk("async_rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst.in_ready",  64'(bus.in_ready),  64'd1);
        chk("async_rst.empty",     64'(bus.empty),     64'd1);
        @(posedge clock);
        #1 reset = 1'b0;
        cycle(0, 1, 0, 32'hD0000003, 20'h00108);
        chk("post_rst.count", 64'(bus.count),           64'd1);
        chk("post_rst.instr", 64'(bus.out_instruction), 64'hD0000003);
        chk("post_rst.pc",    64'(bus.out_PC),          64'h00108);

        // Randomized traffic: filling-biased phase then draining-biased phase.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic f, iv, ordy;
            f    = ($urandom_range(15) == 0);
            iv   = (i < 300) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            ordy = (i < 300) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            cycle(f, iv, ordy, DW'($urandom), AB'($urandom));
            check_model($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
